dram_writer: RTL and testbench
==============================

DRAM_WRITER -- requirements
Module: dram_writer

Interface
REQ-001 Parameter BURST_BEATS, default 16, SHALL set 64-bit beats per AXI burst, legal 1..16, with burst bytes = 8*BURST_BEATS.
REQ-002 fclk  in  1  clock; all logic SHALL be rising-edge; M2S_AXI_ACLK SHALL equal fclk.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 M2S_AXI_ACLK out 1; AWVALID out 1; AWREADY in 1; AWADDR out 32; AWBURST out 2 (=2'b01); AWLEN out 4 (=BURST_BEATS-1); AWSIZE out 2 (=2'b11).
REQ-005 WVALID out 1; WREADY in 1; WDATA out 64; WSTRB out 8 (=8'hFF); WLAST out 1; BVALID in 1; BREADY out 1; BRESP in 2.
REQ-006 wr_frame_valid in 1; wr_frame_ready out 1; wr_BUF_ADDR in 32; wr_FRAME_BYTES in 32 (multiple of burst bytes).
REQ-007 din_burst_valid in 1 (upstream holds >= one full burst); din_valid in 1; din_ready out 1; din in 64.
REQ-008 frame_done out 1 (one-cycle pulse); resp_error out 1 (sticky); debug_state out 3.

Function
REQ-009 States SHALL be S_IDLE, S_FRAME_IDLE, S_ADDR, S_DATA, S_RESP; debug_state SHALL expose the encoding 0..4 respectively.
REQ-010 S_IDLE: wr_frame_ready=1; on wr_frame_valid, latch BUF_ADDR, FRAME_BYTES, set AWADDR=wr_BUF_ADDR, clear resp_error, go S_FRAME_IDLE; FRAME_BYTES==0 SHALL instead pulse frame_done and stay S_IDLE.
REQ-011 S_FRAME_IDLE: when din_burst_valid, assert AWVALID next cycle and enter S_ADDR.
REQ-012 S_ADDR: AWVALID and AWADDR SHALL hold stable until AWVALID&&AWREADY; then deassert AWVALID, load beat counter = BURST_BEATS-1, enter S_DATA.
REQ-013 S_DATA: WVALID = din_valid, din_ready = WREADY, WDATA = din combinationally; a beat transfers when WVALID&&WREADY and decrements the counter.
REQ-014 WLAST SHALL be 1 exactly while counter==0 in S_DATA; transfer of the WLAST beat SHALL enter S_RESP.
REQ-015 S_RESP: BREADY=1; on BVALID, set resp_error if BRESP!=2'b00, AWADDR += burst bytes (mod 2^32), then S_IDLE with frame_done pulse if old AWADDR + burst bytes == BUF_ADDR+FRAME_BYTES (32-bit wrap), else S_FRAME_IDLE.
REQ-016 Exactly one burst SHALL be outstanding; AW of burst N+1 SHALL NOT issue before B of burst N.
REQ-017 Outside S_DATA: WVALID=0, din_ready=0, WLAST=0; outside S_RESP: BREADY=0; outside S_IDLE: wr_frame_ready=0.
REQ-018 wr_frame_valid outside S_IDLE SHALL be ignored; latched config SHALL not change mid-frame.
REQ-019 din_valid low mid-burst SHALL stall the burst without dropping or duplicating beats; WREADY low SHALL stall din.
REQ-020 Error responses SHALL not abort the frame; subsequent bursts continue.

Reset
REQ-021 On rst_n low, immediately: state=S_IDLE, AWADDR=0, AWVALID=0, counter=0, resp_error=0, frame_done=0, latched BUF_ADDR/FRAME_BYTES=0; combinational outputs follow S_IDLE values.
REQ-022 Reset mid-burst SHALL abandon the burst; recovery requires a new frame handshake; interconnect recovery is out of scope.

Structure
REQ-023 Shared package dram_axi_pkg SHALL hold state enum, AXI burst/size constants, and BURST_BEATS default, shared with the read path.
REQ-024 No sub-module; single module, target 150-250 lines.

Verification
REQ-025 Frame BUF_ADDR=0x1000_0000, FRAME_BYTES=256, all ready -> AW at 0x1000_0000 then 0x1000_0080, 32 beats in order, WLAST on beats 16 and 32, one frame_done pulse after second B.
REQ-026 AWREADY held low 5 cycles -> AWVALID/AWADDR stable for all 6 cycles, no W beat before AW handshake.
REQ-027 din_valid toggling and WREADY random 50% -> exactly 16 beats per burst, data sequence 0..15 unchanged, no duplicates.
REQ-028 BRESP=2'b10 on first of 2 bursts -> resp_error=1 persisting, second burst still issued, cleared at next frame accept.
REQ-029 BUF_ADDR=0xFFFF_FF80, FRAME_BYTES=256 -> AWADDR 0xFFFF_FF80 then 0x0000_0000, frame_done after second B.
REQ-030 rst_n low during beat 7 -> all outputs reset asynchronously; new frame after release completes normally.

Source files
------------

// File: rtl/dram_axi_pkg.sv
// Shared definitions for the DRAM AXI write and read paths:
// FSM state encoding, fixed AXI burst attributes and default burst length.
package dram_axi_pkg;

    localparam int unsigned ADDR_W          = 32;
    localparam int unsigned DATA_W          = 64;
    localparam int unsigned STRB_W          = DATA_W / 8;
    localparam int unsigned LEN_W           = 4;
    localparam int unsigned BEAT_BYTES      = 8;
    localparam int unsigned BURST_BEATS_DEF = 16;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_SIZE_8B    = 2'b11;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_FRAME_IDLE = 3'd1,
        S_ADDR       = 3'd2,
        S_DATA       = 3'd3,
        S_RESP       = 3'd4
    } state_e;

endpackage

// File: rtl/dram_writer.sv
// Streams a frame from an upstream FIFO into DRAM as fixed-length AXI INCR
// bursts, keeping exactly one burst outstanding at a time.
module dram_writer
    import dram_axi_pkg::*;
#(
    parameter int unsigned BURST_BEATS = BURST_BEATS_DEF
) (
    input  logic                fclk,
    input  logic                rst_n,

    output logic                M2S_AXI_ACLK,
    output logic                AWVALID,
    input  logic                AWREADY,
    output logic [ADDR_W-1:0]   AWADDR,
    output logic [1:0]          AWBURST,
    output logic [LEN_W-1:0]    AWLEN,
    output logic [1:0]          AWSIZE,

    output logic                WVALID,
    input  logic                WREADY,
    output logic [DATA_W-1:0]   WDATA,
    output logic [STRB_W-1:0]   WSTRB,
    output logic                WLAST,
    input  logic                BVALID,
    output logic                BREADY,
    input  logic [1:0]          BRESP,

    input  logic                wr_frame_valid,
    output logic                wr_frame_ready,
    input  logic [ADDR_W-1:0]   wr_BUF_ADDR,
    input  logic [ADDR_W-1:0]   wr_FRAME_BYTES,

    input  logic                din_burst_valid,
    input  logic                din_valid,
    output logic                din_ready,
    input  logic [DATA_W-1:0]   din,

    output logic                frame_done,
    output logic                resp_error,
    output logic [2:0]          debug_state
);

    localparam logic [LEN_W-1:0]  BURST_LEN   = LEN_W'(BURST_BEATS - 1);
    localparam logic [ADDR_W-1:0] BURST_BYTES = ADDR_W'(BEAT_BYTES * BURST_BEATS);

    state_e              state_q;
    state_e              next_state;
    logic [LEN_W-1:0]    beat_cnt;
    logic [ADDR_W-1:0]   buf_addr;
    logic [ADDR_W-1:0]   frame_bytes;
    logic [ADDR_W-1:0]   next_addr;
    logic                last_burst;
    logic                beat_xfer;

    assign M2S_AXI_ACLK = fclk;
    assign AWBURST      = AXI_BURST_INCR;
    assign AWLEN        = BURST_LEN;
    assign AWSIZE       = AXI_SIZE_8B;
    assign WSTRB        = '1;
    assign WDATA        = din;
    assign debug_state  = state_q;

    // Frame ends when the burst just acknowledged reaches buf_addr + frame_bytes (mod 2^32).
    assign next_addr  = AWADDR + BURST_BYTES;
    assign last_burst = (next_addr == (buf_addr + frame_bytes));
    assign beat_xfer  = din_valid && WREADY;

    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= next_state;
        end
    end

    always_comb begin
        next_state     = state_q;
        wr_frame_ready = 1'b0;
        WVALID         = 1'b0;
        din_ready      = 1'b0;
        WLAST          = 1'b0;
        BREADY         = 1'b0;
        case (state_q)
            S_IDLE: begin
                wr_frame_ready = 1'b1;
                if (wr_frame_valid && (wr_FRAME_BYTES != '0)) begin
                    next_state = S_FRAME_IDLE;
                end
            end
            S_FRAME_IDLE: begin
                if (din_burst_valid) begin
                    next_state = S_ADDR;
                end
            end
            S_ADDR: begin
                if (AWVALID && AWREADY) begin
                    next_state = S_DATA;
                end
            end
            S_DATA: begin
                WVALID    = din_valid;
                din_ready = WREADY;
                WLAST     = (beat_cnt == '0);
                if (beat_xfer && (beat_cnt == '0)) begin
                    next_state = S_RESP;
                end
            end
            S_RESP: begin
                BREADY = 1'b1;
                if (BVALID) begin
                    next_state = last_burst ? S_IDLE : S_FRAME_IDLE;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Address, beat counter, frame config and status registers.
    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            AWADDR      <= '0;
            AWVALID     <= 1'b0;
            beat_cnt    <= '0;
            buf_addr    <= '0;
            frame_bytes <= '0;
            resp_error  <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (wr_frame_valid) begin
                        buf_addr    <= wr_BUF_ADDR;
                        frame_bytes <= wr_FRAME_BYTES;
                        AWADDR      <= wr_BUF_ADDR;
                        resp_error  <= 1'b0;
                        if (wr_FRAME_BYTES == '0) begin
                            frame_done <= 1'b1;
                        end
                    end
                end
                S_FRAME_IDLE: begin
                    if (din_burst_valid) begin
                        AWVALID <= 1'b1;
                    end
                end
                S_ADDR: begin
                    if (AWREADY) begin
                        AWVALID  <= 1'b0;
                        beat_cnt <= BURST_LEN;
                    end
                end
                S_DATA: begin
                    if (beat_xfer && (beat_cnt != '0)) begin
                        beat_cnt <= beat_cnt - LEN_W'(1);
                    end
                end
                S_RESP: begin
                    if (BVALID) begin
                        if (BRESP != AXI_RESP_OKAY) begin
                            resp_error <= 1'b1;
                        end
                        AWADDR <= next_addr;
                        if (last_burst) begin
                            frame_done <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dram_writer.sv
// Directed bench for dram_writer: a table of frame scenarios driven through a
// cycle-level AXI slave / source model, plus hand sequences for reset and empty frames.
module tb_dram_writer;

    logic        fclk = 1'b0;
    logic        rst_n;
    logic        M2S_AXI_ACLK;
    logic        AWVALID;
    logic        AWREADY;
    logic [31:0] AWADDR;
    logic [1:0]  AWBURST;
    logic [3:0]  AWLEN;
    logic [1:0]  AWSIZE;
    logic        WVALID;
    logic        WREADY;
    logic [63:0] WDATA;
    logic [7:0]  WSTRB;
    logic        WLAST;
    logic        BVALID;
    logic        BREADY;
    logic [1:0]  BRESP;
    logic        wr_frame_valid;
    logic        wr_frame_ready;
    logic [31:0] wr_BUF_ADDR;
    logic [31:0] wr_FRAME_BYTES;
    logic        din_burst_valid;
    logic        din_valid;
    logic        din_ready;
    logic [63:0] din;
    logic        frame_done;
    logic        resp_error;
    logic [2:0]  debug_state;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 fclk = ~fclk;

    dram_writer dut (
        .fclk            (fclk),
        .rst_n           (rst_n),
        .M2S_AXI_ACLK    (M2S_AXI_ACLK),
        .AWVALID         (AWVALID),
        .AWREADY         (AWREADY),
        .AWADDR          (AWADDR),
        .AWBURST         (AWBURST),
        .AWLEN           (AWLEN),
        .AWSIZE          (AWSIZE),
        .WVALID          (WVALID),
        .WREADY          (WREADY),
        .WDATA           (WDATA),
        .WSTRB           (WSTRB),
        .WLAST           (WLAST),
        .BVALID          (BVALID),
        .BREADY          (BREADY),
        .BRESP           (BRESP),
        .wr_frame_valid  (wr_frame_valid),
        .wr_frame_ready  (wr_frame_ready),
        .wr_BUF_ADDR     (wr_BUF_ADDR),
        .wr_FRAME_BYTES  (wr_FRAME_BYTES),
        .din_burst_valid (din_burst_valid),
        .din_valid       (din_valid),
        .din_ready       (din_ready),
        .din             (din),
        .frame_done      (frame_done),
        .resp_error      (resp_error),
        .debug_state     (debug_state)
    );

    typedef struct {
        logic [31:0] buf_addr;
        logic [31:0] bytes;
        int          nb;
        int          aw_delay;
        logic [1:0]  resp0;
        bit          toggle;
        bit          rnd_wready;
        int          abort_beat;
        logic [31:0] a0;
        logic [31:0] a1;
        logic [31:0] a2;
        bit          exp_err;
    } frame_vec_t;

    frame_vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        AWREADY         = 1'b0;
        WREADY          = 1'b0;
        BVALID          = 1'b0;
        BRESP           = 2'b00;
        wr_frame_valid  = 1'b0;
        wr_BUF_ADDR     = '0;
        wr_FRAME_BYTES  = '0;
        din_burst_valid = 1'b0;
        din_valid       = 1'b0;
        din             = '0;
    endtask

    function automatic logic [31:0] exp_addr(input frame_vec_t v, input int idx);
        if (idx == 0) return v.a0;
        if (idx == 1) return v.a1;
        return v.a2;
    endfunction

    task automatic run_frame(input frame_vec_t v, input int fid);
        int aw_cnt = 0, b_cnt = 0, done_cnt = 0, beats = 0, wbeat = 0;
        int src_idx = 0, aw_wait = 0, post = 0;
        bit in_burst = 0, b_pending = 0, aw_hold = 0, aborted = 0;
        logic [31:0] held_addr = '0;
        logic [63:0] base;
        base = {32'hA5A5_0000 | 32'(fid), 32'h0};

        // frame handshake
        @(negedge fclk);
        wr_frame_valid = 1'b1;
        wr_BUF_ADDR    = v.buf_addr;
        wr_FRAME_BYTES = v.bytes;
        #1;
        check("frame_ready_idle", 64'(wr_frame_ready), 64'd1);
        @(negedge fclk);
        wr_frame_valid = 1'b0;
        #1;
        check("state_frame_idle", 64'(debug_state), 64'd1);
        check("err_clear", 64'(resp_error), 64'd0);
        check("awaddr_latch", 64'(AWADDR), 64'(v.a0));

        for (int cyc = 0; cyc < 800; cyc++) begin
            @(negedge fclk);
            din_burst_valid = 1'b1;
            // garbage frame requests while busy must be ignored
            wr_frame_valid  = (aw_cnt < v.nb);
            wr_BUF_ADDR     = 32'hDEAD_0000;
            wr_FRAME_BYTES  = 32'd128;
            AWREADY   = AWVALID && (aw_wait >= v.aw_delay);
            din_valid = v.toggle ? 1'(cyc % 2) : 1'b1;
            WREADY    = v.rnd_wready ? 1'($urandom_range(1, 0)) : 1'b1;
            din       = base + 64'(src_idx);
            BVALID    = b_pending;
            BRESP     = (b_cnt == 0) ? v.resp0 : 2'b00;
            #1;
            if (wr_frame_valid) check("frame_ready_busy", 64'(wr_frame_ready), 64'd0);
            if (aw_hold) begin
                check("aw_stable_valid", 64'(AWVALID), 64'd1);
                check("aw_stable_addr", 64'(AWADDR), 64'(held_addr));
            end
            if (AWVALID && AWREADY) begin
                check("awaddr", 64'(AWADDR), 64'(exp_addr(v, aw_cnt)));
                check("one_outstanding", 64'(aw_cnt), 64'(b_cnt));
                check("aw_attrs", {58'd0, AWLEN, AWSIZE}, {58'd0, 4'd15, 2'b11});
                if (aw_cnt == 1) check("err_mid", 64'(resp_error), 64'(v.exp_err));
                aw_cnt++;
                aw_hold  = 0;
                aw_wait  = 0;
                in_burst = 1;
                wbeat    = 0;
            end else if (AWVALID) begin
                aw_hold   = 1;
                held_addr = AWADDR;
                aw_wait++;
            end
            if (WVALID && !in_burst) check("w_early", 64'(WVALID), 64'd0);
            if (WVALID && WREADY) begin
                check("wdata", WDATA, base + 64'(beats));
                check("wlast", 64'(WLAST), 64'(wbeat == 15));
                beats++;
                wbeat++;
                if (WLAST) begin
                    in_burst  = 0;
                    b_pending = 1;
                end
            end
            if (din_valid && din_ready) src_idx++;
            if (BVALID && BREADY) begin
                b_cnt++;
                b_pending = 0;
            end
            if (frame_done) begin
                check("done_order", 64'(b_cnt), 64'(v.nb));
                done_cnt++;
            end
            if (v.abort_beat != 0 && beats == v.abort_beat) begin
                #2;
                rst_n = 1'b0;
                #1;
                check("rst_awvalid", 64'(AWVALID), 64'd0);
                check("rst_awaddr", 64'(AWADDR), 64'd0);
                check("rst_state", 64'(debug_state), 64'd0);
                check("rst_wvalid", 64'(WVALID), 64'd0);
                check("rst_frame_ready", 64'(wr_frame_ready), 64'd1);
                aborted = 1;
                break;
            end
            if (done_cnt > 0) post++;
            if (post >= 3) break;
        end

        idle_inputs();
        if (aborted) begin
            @(negedge fclk);
            rst_n = 1'b1;
            return;
        end
        check("aw_count", 64'(aw_cnt), 64'(v.nb));
        check("beat_count", 64'(beats), 64'(v.nb * 16));
        check("b_count", 64'(b_cnt), 64'(v.nb));
        check("done_pulses", 64'(done_cnt), 64'd1);
        check("err_final", 64'(resp_error), 64'(v.exp_err));
        check("state_end", 64'(debug_state), 64'd0);
    endtask

    initial begin
        vecs[0] = '{32'h1000_0000, 32'd256, 2, 0, 2'b00, 1'b0, 1'b0, 0,
                    32'h1000_0000, 32'h1000_0080, 32'h0, 1'b0};
        vecs[1] = '{32'h2000_0000, 32'd256, 2, 5, 2'b00, 1'b0, 1'b0, 0,
                    32'h2000_0000, 32'h2000_0080, 32'h0, 1'b0};
        vecs[2] = '{32'h0000_4000, 32'd128, 1, 1, 2'b00, 1'b1, 1'b1, 0,
                    32'h0000_4000, 32'h0, 32'h0, 1'b0};
        vecs[3] = '{32'h3000_0000, 32'd256, 2, 0, 2'b10, 1'b0, 1'b0, 0,
                    32'h3000_0000, 32'h3000_0080, 32'h0, 1'b1};
        vecs[4] = '{32'hFFFF_FF80, 32'd256, 2, 0, 2'b00, 1'b1, 1'b0, 0,
                    32'hFFFF_FF80, 32'h0000_0000, 32'h0, 1'b0};
        vecs[5] = '{32'h0000_0100, 32'd384, 3, 2, 2'b00, 1'b0, 1'b1, 0,
                    32'h0000_0100, 32'h0000_0180, 32'h0000_0200, 1'b0};
        vecs[6] = '{32'h5000_0000, 32'd256, 2, 0, 2'b00, 1'b0, 1'b0, 7,
                    32'h5000_0000, 32'h5000_0080, 32'h0, 1'b0};
        vecs[7] = '{32'h6000_0000, 32'd256, 2, 0, 2'b00, 1'b0, 1'b0, 0,
                    32'h6000_0000, 32'h6000_0080, 32'h0, 1'b0};

        idle_inputs();
        din_valid = 1'b1;
        WREADY    = 1'b1;
        rst_n     = 1'b0;
        #12;
        check("reset_state", 64'(debug_state), 64'd0);
        check("reset_awvalid", 64'(AWVALID), 64'd0);
        check("reset_awaddr", 64'(AWADDR), 64'd0);
        check("reset_frame_ready", 64'(wr_frame_ready), 64'd1);
        check("reset_w_outputs", {60'd0, WVALID, din_ready, WLAST, BREADY}, 64'd0);
        check("reset_status", {62'd0, resp_error, frame_done}, 64'd0);
        check("const_attrs", {48'd0, WSTRB, AWBURST, AWSIZE, AWLEN},
              {48'd0, 8'hFF, 2'b01, 2'b11, 4'hF});
        @(negedge fclk);
        idle_inputs();
        rst_n = 1'b1;
        #1;
        check("aclk_low", 64'(M2S_AXI_ACLK), 64'(fclk));

        // zero-length frame completes immediately
        @(negedge fclk);
        wr_frame_valid = 1'b1;
        wr_BUF_ADDR    = 32'h7000_0000;
        wr_FRAME_BYTES = 32'd0;
        @(negedge fclk);
        wr_frame_valid = 1'b0;
        #1;
        check("zero_done", 64'(frame_done), 64'd1);
        check("zero_state", 64'(debug_state), 64'd0);
        @(negedge fclk);
        #1;
        check("zero_done_pulse", 64'(frame_done), 64'd0);

        for (int i = 0; i < 8; i++) begin
            run_frame(vecs[i], i);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
